// File: rtl/ccip_mmio_csr.sv
// CCI-P MMIO CSR responder: DFH/AFU ID, SCRATCH, CTRL, STATUS, answered via a two-stage read pipeline.
// Optional read counter at 0x040 is built only when CCIP_MMIO_RD_COUNT_EN is defined.
module ccip_mmio_csr #(
    parameter logic [63:0] AFU_DFH  = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter logic [63:0] AFU_ID_H = 64'h0
) (
    input  logic         pClk,
    input  logic         pck_cp2af_softReset_n,
    input  logic [27:0]  c0Rx_hdr,
    input  logic [511:0] c0Rx_data,
    input  logic         c0Rx_mmioRdValid,
    input  logic         c0Rx_mmioWrValid,
    output logic [8:0]   c2Tx_hdr,
    output logic         c2Tx_mmioRdValid,
    output logic [63:0]  c2Tx_data,
    output logic         csr_enable,
    output logic         csr_start,
    input  logic [63:0]  csr_status
);

    localparam logic [3:0] IDX_DFH     = 4'd0;
    localparam logic [3:0] IDX_ID_L    = 4'd1;
    localparam logic [3:0] IDX_ID_H    = 4'd2;
    localparam logic [3:0] IDX_SCRATCH = 4'd5;
    localparam logic [3:0] IDX_CTRL    = 4'd6;
    localparam logic [3:0] IDX_STATUS  = 4'd7;
    localparam logic [3:0] IDX_RDCNT   = 4'd8;
    localparam logic [3:0] IDX_NONE    = 4'd15;

    logic [15:0] req_dw_s;
    logic        req_len8_s;
    logic        req_half_s;
    logic [3:0]  req_idx_s;
    logic [63:0] req_local_s;
    logic [63:0] rd_count_s;
    logic        unused_ok_s;

    logic [63:0] scratch_q, scratch_d;
    logic        enable_q, enable_d;
    logic        start_d;

    logic        s1_valid_q;
    logic [8:0]  s1_tid_q;
    logic [3:0]  s1_idx_q;
    logic        s1_half_q;
    logic        s1_len8_q;
    logic [63:0] s1_local_q;

    logic [63:0] s2_reg_s;
    logic [63:0] s2_data_s;

    assign unused_ok_s = ^{c0Rx_hdr[9], c0Rx_data[511:64]};
    assign csr_enable  = enable_q;

    // Request decode: map the DWORD address onto a 64-bit register index
    always_comb begin
        req_dw_s   = c0Rx_hdr[27:12];
        req_len8_s = (c0Rx_hdr[11:10] == 2'b01);
        req_half_s = req_dw_s[0];
        if (req_dw_s[15:1] < 15'd9) begin
            req_idx_s = req_dw_s[4:1];
        end else begin
            req_idx_s = IDX_NONE;
        end
    end

`ifdef CCIP_MMIO_RD_COUNT_EN
    logic [63:0] rd_count_q;

    // Read counter: one increment per accepted read, wraps naturally
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rd_count_q <= 64'h0;
        end else if (c0Rx_mmioRdValid) begin
            rd_count_q <= rd_count_q + 64'd1;
        end
    end

    assign rd_count_s = rd_count_q;
`else
    assign rd_count_s = 64'h0;
`endif

    // Snapshot of locally-held registers at request time, so same-cycle writes are not seen
    always_comb begin
        case (req_idx_s)
            IDX_SCRATCH: req_local_s = scratch_q;
            IDX_CTRL:    req_local_s = {62'h0, enable_q, 1'b0};
            IDX_RDCNT:   req_local_s = rd_count_s;
            default:     req_local_s = 64'h0;
        endcase
    end

    // Write decode: half-select for 4B, aligned-only for 8B; CTRL lives in the lower half
    always_comb begin
        scratch_d = scratch_q;
        enable_d  = enable_q;
        start_d   = 1'b0;
        if (c0Rx_mmioWrValid) begin
            case (req_idx_s)
                IDX_SCRATCH: begin
                    if (req_len8_s) begin
                        if (!req_half_s) begin
                            scratch_d = c0Rx_data[63:0];
                        end else begin
                            scratch_d = scratch_q;
                        end
                    end else if (req_half_s) begin
                        scratch_d[63:32] = c0Rx_data[31:0];
                    end else begin
                        scratch_d[31:0] = c0Rx_data[31:0];
                    end
                end
                IDX_CTRL: begin
                    if (!req_half_s) begin
                        enable_d = c0Rx_data[1];
                        start_d  = c0Rx_data[0];
                    end else begin
                        enable_d = enable_q;
                    end
                end
                default: begin
                    scratch_d = scratch_q;
                end
            endcase
        end else begin
            start_d = 1'b0;
        end
    end

    // Control/scratch state and the registered start pulse
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            scratch_q <= 64'h0;
            enable_q  <= 1'b0;
            csr_start <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            enable_q  <= enable_d;
            csr_start <= start_d;
        end
    end

    // Read stage 1: capture tid, index, half, length and local snapshot
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            s1_valid_q <= 1'b0;
            s1_tid_q   <= 9'h0;
            s1_idx_q   <= IDX_NONE;
            s1_half_q  <= 1'b0;
            s1_len8_q  <= 1'b0;
            s1_local_q <= 64'h0;
        end else begin
            s1_valid_q <= c0Rx_mmioRdValid;
            if (c0Rx_mmioRdValid) begin
                s1_tid_q   <= c0Rx_hdr[8:0];
                s1_idx_q   <= req_idx_s;
                s1_half_q  <= req_half_s;
                s1_len8_q  <= req_len8_s;
                s1_local_q <= req_local_s;
            end
        end
    end

    // Stage 2 data mux; STATUS is sampled here
    always_comb begin
        case (s1_idx_q)
            IDX_DFH:     s2_reg_s = AFU_DFH;
            IDX_ID_L:    s2_reg_s = AFU_ID_L;
            IDX_ID_H:    s2_reg_s = AFU_ID_H;
            IDX_STATUS:  s2_reg_s = csr_status;
            IDX_SCRATCH,
            IDX_CTRL,
            IDX_RDCNT:   s2_reg_s = s1_local_q;
            default:     s2_reg_s = 64'h0;
        endcase
        if (s1_len8_q) begin
            s2_data_s = s1_half_q ? 64'h0 : s2_reg_s;
        end else if (s1_half_q) begin
            s2_data_s = {32'h0, s2_reg_s[63:32]};
        end else begin
            s2_data_s = {32'h0, s2_reg_s[31:0]};
        end
    end

    // Read stage 2: registered response onto c2Tx
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            c2Tx_mmioRdValid <= 1'b0;
            c2Tx_hdr         <= 9'h0;
            c2Tx_data        <= 64'h0;
        end else begin
            c2Tx_mmioRdValid <= s1_valid_q;
            if (s1_valid_q) begin
                c2Tx_hdr  <= s1_tid_q;
                c2Tx_data <= s2_data_s;
            end
        end
    end

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// Scoreboard bench for ccip_mmio_csr: randomized MMIO traffic against an abstract register-map model.
// Honours CCIP_MMIO_RD_COUNT_EN the same way as the design.
module tb_ccip_mmio_csr;

    localparam logic [63:0] DFH = 64'h1000_0000_0000_1000;

    logic         pClk = 1'b0;
    logic         rst_n;
    logic [27:0]  c0Rx_hdr;
    logic [511:0] c0Rx_data;
    logic         c0Rx_mmioRdValid;
    logic         c0Rx_mmioWrValid;
    logic [8:0]   c2Tx_hdr;
    logic         c2Tx_mmioRdValid;
    logic [63:0]  c2Tx_data;
    logic         csr_enable;
    logic         csr_start;
    logic [63:0]  csr_status;

    ccip_mmio_csr dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .c0Rx_hdr              (c0Rx_hdr),
        .c0Rx_data             (c0Rx_data),
        .c0Rx_mmioRdValid      (c0Rx_mmioRdValid),
        .c0Rx_mmioWrValid      (c0Rx_mmioWrValid),
        .c2Tx_hdr              (c2Tx_hdr),
        .c2Tx_mmioRdValid      (c2Tx_mmioRdValid),
        .c2Tx_data             (c2Tx_data),
        .csr_enable            (csr_enable),
        .csr_start             (csr_start),
        .csr_status            (csr_status)
    );

    always #5 pClk = ~pClk;

    int cyc = 0;
    always @(posedge pClk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    bit          start_at[int];
    int          n_checks = 0;
    int          n_errors = 0;

    // Abstract model state
    logic [63:0] m_scratch = 64'h0;
    logic        m_enable  = 1'b0;
    logic [63:0] m_count   = 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] dw, input bit len8);
        logic [63:0] v;
        int unsigned idx;
        idx = int'(dw) / 2;
        if (idx == 0)      v = DFH;
        else if (idx == 5) v = m_scratch;
        else if (idx == 6) v = {62'd0, m_enable, 1'b0};
        else if (idx == 7) v = csr_status;
`ifdef CCIP_MMIO_RD_COUNT_EN
        else if (idx == 8) v = m_count;
`endif
        else               v = 64'd0;
        if (len8) return dw[0] ? 64'd0 : v;
        return dw[0] ? {32'd0, v[63:32]} : {32'd0, v[31:0]};
    endfunction

    task automatic model_write(input logic [15:0] dw, input bit len8, input logic [63:0] d);
        int unsigned idx;
        idx = int'(dw) / 2;
        if (idx == 5) begin
            if (len8) begin
                if (!dw[0]) m_scratch = d;
            end else if (dw[0]) begin
                m_scratch[63:32] = d[31:0];
            end else begin
                m_scratch[31:0] = d[31:0];
            end
        end else if (idx == 6 && !dw[0]) begin
            m_enable = d[1];
            if (d[0]) start_at[cyc + 1] = 1'b1;
        end
    endtask

    task automatic op(input bit rd, input bit wr, input logic [15:0] dw,
                      input logic [1:0] len, input logic [8:0] tid, input logic [63:0] d);
        exp_t e;
        @(negedge pClk);
        c0Rx_hdr         = {dw, len, 1'b0, tid};
        c0Rx_data        = {{14{32'hA5A5_5A5A}}, d};
        c0Rx_mmioRdValid = rd;
        c0Rx_mmioWrValid = wr;
        if (rd) begin
            e.tid  = tid;
            e.data = model_read(dw, len == 2'b01);
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_count = m_count + 64'd1;
        end
        if (wr) model_write(dw, len == 2'b01, d);
    endtask

    task automatic idle();
        @(negedge pClk);
        c0Rx_mmioRdValid = 1'b0;
        c0Rx_mmioWrValid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle();
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge pClk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  {63'd0, c2Tx_mmioRdValid}, 64'd0);
        chk({tag, "_hdr"},    {55'd0, c2Tx_hdr},         64'd0);
        chk({tag, "_data"},   c2Tx_data,                 64'd0);
        chk({tag, "_enable"}, {63'd0, csr_enable},       64'd0);
        chk({tag, "_start"},  {63'd0, csr_start},        64'd0);
    endtask

    // Monitor: pops the scoreboard on every response, checks control outputs each cycle
    initial begin
        exp_t e;
        bit   exp_start;
        forever begin
            @(posedge pClk);
            #1;
            if (rst_n) begin
                if (c2Tx_mmioRdValid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp actual_valid=1 required_valid=0 hdr=%h", c2Tx_hdr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_tid",     {55'd0, c2Tx_hdr}, {55'd0, e.tid});
                        chk("rsp_data",    c2Tx_data, e.data);
                        chk("rsp_latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                exp_start = start_at.exists(cyc);
                if (exp_start) start_at.delete(cyc);
                chk("csr_start",  {63'd0, csr_start},  {63'd0, exp_start});
                chk("csr_enable", {63'd0, csr_enable}, {63'd0, m_enable});
            end
        end
    end

    initial begin
        logic [15:0] dw;
        logic [1:0]  len;
        bit          rd, wr;
        int unsigned r;

        rst_n            = 1'b0;
        c0Rx_hdr         = 28'd0;
        c0Rx_data        = 512'd0;
        c0Rx_mmioRdValid = 1'b0;
        c0Rx_mmioWrValid = 1'b0;
        csr_status       = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(negedge pClk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed scenarios
        op(1'b1, 1'b0, 16'h0000, 2'b01, 9'h1A5, 64'd0);
        op(1'b0, 1'b1, 16'h000A, 2'b01, 9'h000, 64'hDEAD_BEEF_0123_4567);
        op(1'b1, 1'b0, 16'h000B, 2'b00, 9'h002, 64'd0);
        op(1'b1, 1'b0, 16'h000B, 2'b01, 9'h003, 64'd0);
        op(1'b0, 1'b1, 16'h000C, 2'b01, 9'h000, 64'h3);
        idle();
        op(1'b1, 1'b0, 16'h000C, 2'b01, 9'h004, 64'd0);
        op(1'b0, 1'b1, 16'h000D, 2'b00, 9'h000, 64'h1);
        op(1'b1, 1'b0, 16'h000E, 2'b01, 9'h001, 64'd0);
        op(1'b1, 1'b0, 16'h0002, 2'b01, 9'h002, 64'd0);
        op(1'b1, 1'b0, 16'h000A, 2'b00, 9'h003, 64'd0);
        op(1'b1, 1'b0, 16'h000F, 2'b00, 9'h004, 64'd0);
        op(1'b1, 1'b1, 16'h000A, 2'b01, 9'h0AA, 64'h1111_2222_3333_4444);
        op(1'b1, 1'b0, 16'h000A, 2'b01, 9'h0AB, 64'd0);
        drain();

        // Randomized phases, STATUS held steady within a phase
        for (int ph = 0; ph < 4; ph++) begin
            csr_status = {$urandom, $urandom};
            for (int i = 0; i < 100; i++) begin
                r  = $urandom_range(0, 15);
                rd = (r < 9) || (r == 15);
                wr = (r >= 9);
                r  = $urandom_range(0, 23);
                if (wr && !rd) r = $urandom_range(0, 3) == 0 ? r : 10 + $urandom_range(0, 3);
                if (r < 20)       dw = 16'(r);
                else if (r == 20) dw = 16'h0040;
                else if (r == 21) dw = 16'h0012;
                else              dw = 16'(r) + 16'h0100;
                len = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
                op(rd, wr, dw, len, 9'($urandom), {$urandom, $urandom});
            end
            drain();
        end

        // Reset with reads in flight
        op(1'b0, 1'b1, 16'h000A, 2'b01, 9'h000, 64'h5555_AAAA_5555_AAAA);
        op(1'b0, 1'b1, 16'h000C, 2'b01, 9'h000, 64'h2);
        op(1'b1, 1'b0, 16'h000A, 2'b01, 9'h031, 64'd0);
        op(1'b1, 1'b0, 16'h000C, 2'b01, 9'h032, 64'd0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        start_at.delete();
        m_scratch = 64'h0;
        m_enable  = 1'b0;
        m_count   = 64'h0;
        idle();
        chk_reset_outputs("midreset");
        repeat (2) @(negedge pClk);
        rst_n = 1'b1;
        repeat (4) @(negedge pClk);
        op(1'b1, 1'b0, 16'h000A, 2'b01, 9'h041, 64'd0);
        op(1'b1, 1'b0, 16'h000C, 2'b01, 9'h042, 64'd0);
        op(1'b1, 1'b0, 16'h0000, 2'b01, 9'h043, 64'd0);
        op(1'b1, 1'b0, 16'h0010, 2'b01, 9'h044, 64'd0);
        op(1'b1, 1'b0, 16'h0010, 2'b00, 9'h045, 64'd0);
        op(1'b1, 1'b0, 16'h0040, 2'b01, 9'h046, 64'd0);
        drain();
`ifdef CCIP_MMIO_RD_COUNT_EN
        chk("rd_count_model", m_count, 64'd6);
`endif

        repeat (3) @(negedge pClk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
